// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg
// Shared constants for the ALU/UART sequencing front-end:
//   - 3-bit state encodings of the sequencer FSM
//   - ALU operation codes (6-bit), also used by the testbench
package alu_uart_pkg;

  // Sequencer states
  localparam logic [2:0] S_A       = 3'd0;  // waiting for operand A
  localparam logic [2:0] S_B       = 3'd1;  // waiting for operand B
  localparam logic [2:0] S_OP      = 3'd2;  // waiting for operation code
  localparam logic [2:0] S_EXEC    = 3'd3;  // ALU inputs stable, capture result
  localparam logic [2:0] S_WAIT_TX = 3'd4;  // result handed to transmitter

  // ALU operation codes
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Collects operand A, operand B and an operation code from the UART receiver,
// holds them on the ALU inputs, then captures the ALU result and hands it to
// the UART transmitter with a one-cycle start pulse, waiting for tx_done.
//
// Parameters:
//   lenD  data/operand width (UART byte width)
//   lenO  operation code width, must not exceed lenD
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   received byte, valid while rx_done is high
//   rx_done     in   one-cycle pulse, new byte on rx_data
//   alu_result  in   combinational ALU result
//   tx_done     in   one-cycle pulse, transmitter finished the byte
//   nr1         out  operand A to the ALU
//   nr2         out  operand B to the ALU
//   operacion   out  operation code to the ALU
//   tx_data     out  result byte to the transmitter
//   tx_start    out  one-cycle pulse, transmitter loads tx_data
//   busy        out  high while a result is being executed/transmitted
//   overrun     out  sticky, a received byte was dropped
module alu_uart_interface
  import alu_uart_pkg::*;
#(
  parameter int unsigned lenD = 8,
  parameter int unsigned lenO = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [lenD-1:0] rx_data,
  input  logic            rx_done,
  input  logic [lenD-1:0] alu_result,
  input  logic            tx_done,
  output logic [lenD-1:0] nr1,
  output logic [lenD-1:0] nr2,
  output logic [lenO-1:0] operacion,
  output logic [lenD-1:0] tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            overrun
);

  logic [2:0]      r_state;
  logic [2:0]      w_state_next;
  logic [lenD-1:0] r_nr1;
  logic [lenD-1:0] r_nr2;
  logic [lenO-1:0] r_operacion;
  logic [lenD-1:0] r_tx_data;
  logic            r_tx_start;
  logic            r_overrun;

  logic            w_busy;
  logic            w_rx_drop;

  // While a result is in flight there is nowhere to put a new byte.
  assign w_busy    = (r_state == S_EXEC) || (r_state == S_WAIT_TX);
  assign w_rx_drop = rx_done && w_busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_A:       if (rx_done) w_state_next = S_B;
      S_B:       if (rx_done) w_state_next = S_OP;
      S_OP:      if (rx_done) w_state_next = S_EXEC;
      S_EXEC:    w_state_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_done) w_state_next = S_A;
      default:   w_state_next = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_A;
      r_nr1       <= '0;
      r_nr2       <= '0;
      r_operacion <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == S_A) && rx_done) r_nr1 <= rx_data;
      if ((r_state == S_B) && rx_done) r_nr2 <= rx_data;
      // Upper bits of the op byte are discarded without validation.
      if ((r_state == S_OP) && rx_done) r_operacion <= rx_data[lenO-1:0];

      // ALU inputs have been stable for a full cycle in S_EXEC.
      if (r_state == S_EXEC) r_tx_data <= alu_result;
      r_tx_start <= (r_state == S_EXEC);

      if (w_rx_drop) r_overrun <= 1'b1;
    end
  end

  assign nr1       = r_nr1;
  assign nr2       = r_nr2;
  assign operacion = r_operacion;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Testbench for alu_uart_interface: directed sequences with literal
// expectations, then randomized rx/tx traffic checked every cycle against a
// transaction-level model of the byte sequencing.
module tb_alu_uart_interface;
  import alu_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] nr1, nr2, tx_data;
  logic [5:0] operacion;
  logic       tx_start, busy, overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(.lenD(8), .lenO(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .alu_result(alu_result),
    .tx_done   (tx_done),
    .nr1       (nr1),
    .nr2       (nr2),
    .operacion (operacion),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Reference ALU: operands signed.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(nr1, nr2, operacion);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: count bytes of the current triple, then one cycle of
  // execution, then wait for the transmitter.
  int         got;
  bit         exec_now, wait_tx, was_exec;
  logic [7:0] m_a, m_b, m_txd;
  logic [5:0] m_op;
  bit         m_start, m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got = 0; exec_now = 0; wait_tx = 0;
      m_a = 0; m_b = 0; m_op = 0; m_txd = 0; m_start = 0; m_ovr = 0;
    end else begin
      was_exec = exec_now;
      if (exec_now) begin
        m_txd    = alu_f(m_a, m_b, m_op);
        exec_now = 0;
        wait_tx  = 1;
        if (rx_done) m_ovr = 1;
      end else if (wait_tx) begin
        if (rx_done) m_ovr = 1;
        if (tx_done) wait_tx = 0;
      end else if (rx_done) begin
        if (got == 0) begin m_a = rx_data; got = 1; end
        else if (got == 1) begin m_b = rx_data; got = 2; end
        else begin m_op = rx_data[5:0]; got = 0; exec_now = 1; end
      end
      m_start = was_exec;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("nr1", nr1, m_a);
      chk("nr2", nr2, m_b);
      chk("operacion", operacion, m_op);
      chk("tx_data", tx_data, m_txd);
      chk("tx_start", tx_start, m_start);
      chk("busy", busy, exec_now || wait_tx);
      chk("overrun", overrun, m_ovr);
    end
  end

  // Drive inputs for one cycle; returns 1 ns after the sampling edge.
  task automatic step(input logic rv, input logic [7:0] rd, input logic td);
    rx_done = rv; rx_data = rd; tx_done = td;
    @(posedge clk);
    #1;
    rx_done = 0; tx_done = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_nr1"}, nr1, 0);
    chk({tag, "_nr2"}, nr2, 0);
    chk({tag, "_op"}, operacion, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  logic [5:0] ops [8];
  logic [7:0] b;

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    rst_n = 0; rx_done = 0; rx_data = 0; tx_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    step(0, 0, 0);

    // ADD 5 + 3
    step(1, 8'h05, 0); step(1, 8'h03, 0); step(1, 8'h20, 0);
    chk("add_nr1", nr1, 8'h05);
    chk("add_nr2", nr2, 8'h03);
    chk("add_op", operacion, 6'b100000);
    chk("add_busy", busy, 1);
    chk("add_start_t1", tx_start, 0);
    step(0, 0, 0);
    chk("add_start_t2", tx_start, 1);
    chk("add_txd", tx_data, 8'h08);
    step(0, 0, 0);
    chk("add_start_t3", tx_start, 0);
    step(0, 0, 1);
    chk("add_idle", busy, 0);

    // SUB 3 - 5
    step(1, 8'h03, 0); step(1, 8'h05, 0); step(1, 8'h22, 0);
    step(0, 0, 0);
    chk("sub_txd", tx_data, 8'hFE);
    step(0, 0, 1);
    chk("sub_idle", busy, 0);

    // Op byte upper bits discarded
    step(1, 8'hFF, 0); step(1, 8'h01, 0); step(1, 8'hE0, 0);
    chk("upper_op", operacion, 6'b100000);
    step(0, 0, 0);
    chk("upper_txd", tx_data, 8'h00);

    // Overrun in S_WAIT_TX
    step(1, 8'hAA, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_nr1", nr1, 8'hFF);
    chk("ovr_busy", busy, 1);
    step(0, 0, 1);
    step(1, 8'h0F, 0); step(1, 8'hF0, 0); step(1, 8'h25, 0);
    step(0, 0, 0);
    chk("or_txd", tx_data, 8'hFF);
    chk("or_ovr", overrun, 1);

    // Simultaneous tx_done and rx_done
    step(1, 8'h11, 1);
    chk("sim_busy", busy, 0);
    chk("sim_ovr", overrun, 1);
    chk("sim_nr1", nr1, 8'h0F);
    step(1, 8'h22, 0);
    chk("sim_next_nr1", nr1, 8'h22);
    step(1, 8'h01, 0); step(1, 8'h20, 0);
    step(0, 0, 0);
    chk("sim_txd", tx_data, 8'h23);
    step(0, 0, 1);

    // Reset mid-sequence
    step(1, 8'h07, 0); step(1, 8'h09, 0);
    chk("mid_nr2", nr2, 8'h09);
    #2 rst_n = 0;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rst_n = 1;
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h20, 0);
    chk("post_nr1", nr1, 8'h01);
    step(0, 0, 0);
    chk("post_txd", tx_data, 8'h03);
    chk("post_ovr", overrun, 0);
    step(0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 0;
        step(0, 0, 0);
        rst_n = 1;
      end
      if ($urandom_range(0, 1) == 1)
        b = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
      else
        b = 8'($urandom);
      step($urandom_range(0, 99) < 35, b, $urandom_range(0, 99) < 25);
    end
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequencing front-end for the combinational ALU. It collects three bytes from the UART receiver (operand A, operand B, operation code) and holds them on the ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between the UART rx/tx pair and the ALU at the top level, owning the registers that drive the ALU's `nr1`/`nr2`/`operacion`.

## Interface

- `lenD`, default 8: data/operand width, equal to the UART byte width.
- `lenO`, default 6: operation code width. Must satisfy `lenO <= lenD`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  lenD  byte from the UART receiver; valid only while `rx_done` is high.
- `rx_done`  in  1  single-cycle pulse; a new byte is on `rx_data`.
- `alu_result`  in  lenD  combinational result from the ALU.
- `tx_done`  in  1  single-cycle pulse; the transmitter has finished the current byte.
- `nr1`  out  lenD  operand A to the ALU (registered).
- `nr2`  out  lenD  operand B to the ALU (registered).
- `operacion`  out  lenO  operation code to the ALU (registered).
- `tx_data`  out  lenD  result byte to the transmitter (registered).
- `tx_start`  out  1  single-cycle pulse; the transmitter loads `tx_data`.
- `busy`  out  1  high in `S_EXEC` and `S_WAIT_TX`.
- `overrun`  out  1  sticky flag: a received byte was dropped.

## Operation

FSM states: `S_A`, `S_B`, `S_OP`, `S_EXEC`, `S_WAIT_TX`.

- **`S_A`:** on `rx_done`, `nr1 <= rx_data`, then go to `S_B`.
- **`S_B`:** on `rx_done`, `nr2 <= rx_data`, then go to `S_OP`.
- **`S_OP`:** on `rx_done`, `operacion <= rx_data[lenO-1:0]` (upper bits discarded, no validity check), then go to `S_EXEC`.
- **`S_EXEC`:** unconditionally `tx_data <= alu_result` and `tx_start <= 1`, then go to `S_WAIT_TX`.
- **`S_WAIT_TX`:** `tx_start <= 0`. On `tx_done`, go to `S_A`.
- Bytes are passed raw; the ALU interprets operands as signed.
- `nr1`, `nr2` and `operacion` hold their values until overwritten by the next sequence, so the ALU output stays stable through `S_WAIT_TX`.
- `rx_done` in `S_EXEC` or `S_WAIT_TX`: the byte is dropped, `overrun <= 1`, and the state is unaffected.
- `rx_done` and `tx_done` in the same cycle in `S_WAIT_TX`: go to `S_A`, the byte is dropped, and `overrun <= 1`.
- `tx_done` outside `S_WAIT_TX`: ignored.
- `overrun` is cleared only by reset.
- Reset, including mid-sequence, returns the FSM to `S_A`. The next received byte is treated as operand A.

## Timing

- Reset values: `nr1`=0, `nr2`=0, `operacion`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `overrun`=0, state `S_A`.
- `nr1`, `nr2` and `operacion` update on the edge that samples `rx_done`, so they are visible in cycle t+1.
- Op byte `rx_done` in cycle t:
  - cycle t+1: `S_EXEC`, ALU inputs valid.
  - cycle t+2: `tx_start`=1 and `tx_data` = ALU result.
  - cycle t+3: `tx_start`=0.
- `tx_start` is high for exactly one cycle per sequence and is never asserted twice without an intervening `tx_done`.
- `busy` is decoded from state: high from t+1 until the cycle after `tx_done`.
- Minimum spacing of `rx_done` pulses: 1 cycle. Back-to-back pulses in `S_A`, `S_B`, `S_OP` are all accepted.

## Structure

- Package `alu_uart_pkg` holds:
  - state encoding localparams (3 bits);
  - ALU op code constants `OP_ADD`=6'b100000, `OP_SUB`=6'b100010, `OP_AND`=6'b100100, `OP_OR`=6'b100101, `OP_XOR`=6'b100110, `OP_SRA`=6'b000011, `OP_SRL`=6'b000010, `OP_NOR`=6'b100111, shared with the bench.
- No sub-module: a single FSM module with its output registers.
- The ALU and the UART rx/tx are instantiated beside this block by the top level, not inside it.

## Test plan

- **ADD:** after reset, rx bytes 0x05, 0x03, 0x20 → `nr1`=0x05, `nr2`=0x03, `operacion`=6'b100000; `tx_start` is a one-cycle pulse two cycles after the third `rx_done`, with `tx_data`=0x08.
- **SUB, negative result:** bytes 0x03, 0x05, 0x22 → `tx_data`=0xFE; after `tx_done`, `busy`=0 and state is `S_A`.
- **Op upper bits:** bytes 0xFF, 0x01, 0xE0 → `operacion`=6'b100000 and `tx_data`=0x00.
- **Overrun:** `rx_done` with 0xAA while in `S_WAIT_TX` → byte dropped, `overrun`=1, `nr1` unchanged. Next sequence 0x0F, 0xF0, 0x25 → `tx_data`=0xFF, and `overrun` is still 1.
- **Simultaneous events:** `tx_done` and `rx_done` (0x11) in the same cycle in `S_WAIT_TX` → state `S_A`, `overrun`=1. The following byte 0x22 lands in `nr1`.
- **Reset mid-operation:** assert `rst_n`=0 after bytes 0x07, 0x09 → all outputs return to reset values asynchronously. After release, bytes 0x01, 0x02, 0x20 → `tx_data`=0x03.
